// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch stage.
//   PCSRC_* : pc_mux select encodings
//   NOP_INSTR : instruction presented to decode out of reset (addi x0,x0,0)
//   fetch_state_t : fetch sequencer states
package fetch_pkg;

  localparam logic [1:0]  PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0]  PCSRC_TARGET = 2'b01;
  localparam logic [1:0]  PCSRC_ALU    = 2'b10;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD_REDIR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {instr, pc} holding buffer used when a fetch
// completes while decode is stalled.
//   clk, rst_n           : clock, async active-low reset
//   push, push_instr/pc  : capture an entry
//   pop                  : release the entry (consumer took it)
//   clear                : drop the entry (redirect); wins over push/pop
//   full                 : an entry is held
//   pop_instr, pop_pc    : held entry contents
module fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  output logic        full,
  output logic [31:0] pop_instr,
  output logic [31:0] pop_pc
);

  logic        full_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;

  // Buffer occupancy and contents; clear has priority, then push, then pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r  <= 1'b0;
      instr_r <= 32'h0000_0000;
      pc_r    <= 32'h0000_0000;
    end else if (clear) begin
      full_r  <= 1'b0;
    end else if (push) begin
      full_r  <= 1'b1;
      instr_r <= push_instr;
      pc_r    <= push_pc;
    end else if (pop) begin
      full_r  <= 1'b0;
    end else begin
      full_r  <= full_r;
    end
  end

  assign full      = full_r;
  assign pop_instr = instr_r;
  assign pop_pc    = pc_r;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Owns the PC, runs the req/ready
// handshake with instruction memory, applies stall and redirects, and
// hands instructions to decode.
//   clk, rst_n                 : clock, async active-low reset
//   BR_TAKEN, JALR             : redirect requests from execute
//   STALL                      : hazard unit hold
//   PC_next / PC_SRC / PC      : pc_mux result, select, and current PC
//   IMEM_REQ/ADDR/READY/RDATA  : instruction memory handshake
//   INSTR, INSTR_VALID, PC_D   : registered outputs toward decode
//   FLUSH_D                    : combinational decode kill on redirect
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        BR_TAKEN,
  input  logic        JALR,
  input  logic        STALL,
  input  logic [31:0] PC_next,
  output logic [1:0]  PC_SRC,
  output logic [31:0] PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTR,
  output logic        INSTR_VALID,
  output logic [31:0] PC_D,
  output logic        FLUSH_D
);

  import fetch_pkg::*;

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  redir_pc_r;
  logic         req_pending_r;
  logic [31:0]  instr_r;
  logic         instr_valid_r;
  logic [31:0]  pc_d_r;

  logic         redir_s;
  logic [1:0]   pc_src_s;
  logic         req_s;
  logic         accept_s;
  logic         skid_full_s;
  logic         skid_push_s;
  logic         skid_pop_s;
  logic [31:0]  skid_instr_s;
  logic [31:0]  skid_pc_s;

  assign redir_s  = BR_TAKEN | JALR;
  // A pending request must stay up regardless of stall so ADDR stays stable.
  assign req_s    = req_pending_r | ((state_r == RUN) & ~STALL & ~skid_full_s);
  assign accept_s = req_s & IMEM_READY;

  // pc_mux select; JALR outranks BR_TAKEN.
  always_comb begin
    pc_src_s = PCSRC_PLUS4;
    if (JALR) begin
      pc_src_s = PCSRC_ALU;
    end else if (BR_TAKEN) begin
      pc_src_s = PCSRC_TARGET;
    end else begin
      pc_src_s = PCSRC_PLUS4;
    end
  end

  // A fetch that lands during stall parks in the skid; it unloads on the
  // first unstalled cycle. A redirect throws it away.
  assign skid_push_s = accept_s & STALL & ~redir_s & (state_r == RUN);
  assign skid_pop_s  = skid_full_s & ~STALL & ~redir_s & (state_r == RUN);

  fetch_skid u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (skid_push_s),
    .pop        (skid_pop_s),
    .clear      (redir_s),
    .push_instr (IMEM_RDATA),
    .push_pc    (pc_r),
    .full       (skid_full_s),
    .pop_instr  (skid_instr_s),
    .pop_pc     (skid_pc_s)
  );

  // Fetch sequencer: state, PC, deferred redirect target, handshake
  // bookkeeping and the decode-side output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC;
      redir_pc_r    <= RESET_PC;
      req_pending_r <= 1'b0;
      instr_r       <= NOP_INSTR;
      instr_valid_r <= 1'b0;
      pc_d_r        <= 32'h0000_0000;
    end else begin
      if (req_s) begin
        req_pending_r <= ~IMEM_READY;
      end else begin
        req_pending_r <= req_pending_r;
      end

      case (state_r)
        BOOT: begin
          state_r <= RUN;
          if (redir_s) begin
            pc_r          <= PC_next;
            instr_valid_r <= 1'b0;
          end else begin
            pc_r          <= pc_r;
          end
        end

        RUN: begin
          if (redir_s) begin
            instr_valid_r <= 1'b0;
            if (req_s & ~IMEM_READY) begin
              // Outstanding request must finish at the old address first.
              redir_pc_r <= PC_next;
              state_r    <= HOLD_REDIR;
            end else begin
              pc_r       <= PC_next;
            end
          end else if (STALL) begin
            if (accept_s) begin
              pc_r <= PC_next;
            end else begin
              pc_r <= pc_r;
            end
          end else if (skid_full_s) begin
            instr_r       <= skid_instr_s;
            pc_d_r        <= skid_pc_s;
            instr_valid_r <= 1'b1;
          end else if (accept_s) begin
            instr_r       <= IMEM_RDATA;
            pc_d_r        <= pc_r;
            instr_valid_r <= 1'b1;
            pc_r          <= PC_next;
          end else begin
            pc_r          <= pc_r;
          end
        end

        HOLD_REDIR: begin
          if (redir_s) begin
            instr_valid_r <= 1'b0;
            if (IMEM_READY) begin
              pc_r    <= PC_next;
              state_r <= RUN;
            end else begin
              redir_pc_r <= PC_next;
            end
          end else if (IMEM_READY) begin
            pc_r    <= redir_pc_r;
            state_r <= RUN;
          end else begin
            pc_r    <= pc_r;
          end
        end

        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

  assign PC_SRC      = pc_src_s;
  assign PC          = pc_r;
  assign IMEM_ADDR   = pc_r;
  assign IMEM_REQ    = req_s;
  assign INSTR       = instr_r;
  assign INSTR_VALID = instr_valid_r;
  assign PC_D        = pc_d_r;
  assign FLUSH_D     = redir_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios followed by random traffic, with every
// cycle checked against a transaction-level model of the fetch stage.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken, jalr, stall, imem_ready;
  logic [31:0] tgt_s, alu_s;
  logic [31:0] pc_next, imem_rdata;
  logic [1:0]  pc_src;
  logic [31:0] pc, imem_addr, instr, pc_d;
  logic        imem_req, instr_valid, flush_d;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .BR_TAKEN(br_taken), .JALR(jalr), .STALL(stall),
    .PC_next(pc_next), .PC_SRC(pc_src), .PC(pc), .IMEM_REQ(imem_req),
    .IMEM_ADDR(imem_addr), .IMEM_READY(imem_ready), .IMEM_RDATA(imem_rdata),
    .INSTR(instr), .INSTR_VALID(instr_valid), .PC_D(pc_d), .FLUSH_D(flush_d)
  );

  // Environment: memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  // Environment: pc_mux.
  assign pc_next = (pc_src == 2'b10) ? alu_s :
                   (pc_src == 2'b01) ? tgt_s : (pc + 32'd4);

  // Reference model: fetch address, outstanding request, deferred redirect,
  // queue of parked instructions, and what decode currently sees.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        skid_q[$];
  logic [31:0] m_pc, m_tgt, m_instr, m_pcd;
  logic        m_boot, m_wait, m_pend, m_valid;

  task automatic model_reset();
    m_pc = RESET_PC; m_tgt = RESET_PC; m_boot = 1'b1; m_wait = 1'b0;
    m_pend = 1'b0; m_valid = 1'b0; m_instr = NOP; m_pcd = 32'h0;
    skid_q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_pc_d"}, pc_d, 32'h0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
  endtask

  // One clock cycle: drive, check at negedge, advance model, pass posedge.
  task automatic step(input logic br, input logic jr, input logic st,
                      input logic rdy, input logic [31:0] tgt, input logic [31:0] alu);
    logic        redir, req;
    logic [31:0] nxt;
    logic [1:0]  src;
    br_taken = br; jalr = jr; stall = st; imem_ready = rdy; tgt_s = tgt; alu_s = alu;
    redir = br | jr;
    src   = jr ? 2'b10 : (br ? 2'b01 : 2'b00);
    nxt   = jr ? alu : (br ? tgt : m_pc + 32'd4);
    req   = m_pend | (!m_boot && !m_wait && !st && skid_q.size() == 0);
    @(negedge clk);
    chk("req", {31'd0, imem_req}, {31'd0, req});
    chk("addr", imem_addr, m_pc);
    chk("pc_src", {30'd0, pc_src}, {30'd0, src});
    chk("flush", {31'd0, flush_d}, {31'd0, redir});
    chk("valid", {31'd0, instr_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("pc_d", pc_d, m_pcd);
    end
    // Model update for the coming edge.
    if (m_boot) begin
      m_boot = 1'b0;
      if (redir) m_pc = nxt;
    end else if (m_wait) begin
      if (redir) begin
        m_valid = 1'b0;
        if (rdy) begin m_pc = nxt; m_wait = 1'b0; end
        else m_tgt = nxt;
      end else if (rdy) begin
        m_pc = m_tgt; m_wait = 1'b0;
      end
    end else if (redir) begin
      m_valid = 1'b0;
      skid_q.delete();
      if (req && !rdy) begin m_tgt = nxt; m_wait = 1'b1; end
      else m_pc = nxt;
    end else if (st) begin
      if (req && rdy) begin
        skid_q.push_back('{instr: mem_word(m_pc), pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end else if (skid_q.size() != 0) begin
      m_instr = skid_q[0].instr; m_pcd = skid_q[0].pc; m_valid = 1'b1;
      void'(skid_q.pop_front());
    end else if (req && rdy) begin
      m_instr = mem_word(m_pc); m_pcd = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    if (req) m_pend = !rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; br_taken = 1'b0; jalr = 1'b0; stall = 1'b0;
    imem_ready = 1'b1; tgt_s = 32'h0; alu_s = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero-wait streaming, then three wait cycles at address 8.
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk("stream_pc", pc, 32'h8);
    repeat (3) step(0, 0, 0, 0, 32'h0, 32'h0);
    chk("wait_pc", pc, 32'h8);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // Branch on an accept cycle, then JALR+BR together.
    step(1, 0, 0, 1, 32'h100, 32'h0);
    chk("br_pc", pc, 32'h100);
    chk("br_valid", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(1, 1, 0, 1, 32'h140, 32'h10);
    chk("jalr_pc", pc, 32'h10);

    // Redirect while the request at 0x10 waits.
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h200, 32'h0);
    chk("hold_addr", imem_addr, 32'h10);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk("hold_pc", pc, 32'h200);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h400, 32'h0);
    step(1, 0, 0, 0, 32'h300, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk("hold_latest", pc, 32'h300);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h500, 32'h0);
    step(1, 0, 0, 1, 32'h600, 32'h0);
    chk("hold_coincide", pc, 32'h600);

    // Stall while the request at 0x20 completes: skid path.
    step(1, 0, 0, 1, 32'h20, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 1, 32'h0, 32'h0);
    step(0, 0, 1, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk("skid_pc_d", pc_d, 32'h20);
    chk("skid_instr", instr, mem_word(32'h20));
    chk("skid_resume", imem_addr, 32'h24);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // PC wrap-around.
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Asynchronous reset while a redirect is deferred.
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h700, 32'h0);
    br_taken = 1'b0; jalr = 1'b0; stall = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("midreset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
